router_merge: RTL and testbench
===============================

# router_merge

Four-to-one merge block, the inverse of the address-decoding router: collects words from four source ports and emits a single stream tagged with the source index. The output is shaped like the router input (data, enable, 2-bit address), so a merge→router pair returns each word to its original port index. Arbitration is round-robin. The output stage is a single registered slot with valid/ready back-pressure.

## Interface
- `DATA_WIDTH`, 32, width of every data word.
- `clk` in 1, single clock; all state updates on the rising edge.
- `resetn` in 1, asynchronous, active-low reset.
- `din0`..`din3` in DATA_WIDTH each, source data for ports 0..3.
- `din_en0`..`din_en3` in 1 each, source valid for ports 0..3.
- `din_rdy0`..`din_rdy3` out 1 each, port accepted this cycle; combinational.
- `dout` out DATA_WIDTH, merged data; forced to 0 whenever `dout_en`=0.
- `dout_en` out 1, output slot holds a valid word.
- `addr` out 2, index of the source port of the word in `dout`; 0 when `dout_en`=0.
- `dout_rdy` in 1, downstream consumes the word when `dout_en`&`dout_rdy`.

## Operation
- Transfer on port i: `din_en`i & `din_rdy`i at a rising edge. Transfer out: `dout_en` & `dout_rdy`.
- `slot_free` = ~`dout_en` | `dout_rdy`. At most one `din_rdy`i is high, and only when `slot_free`=1 and port i is granted.
- Round-robin pointer `ptr`[1:0]: grant goes to the first requesting port scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- On an accept from port g: slot ← {din_g, g}, `dout_en`←1, `ptr`←g+1 (mod 4, 3 wraps to 0).
- No accept: `ptr` unchanged. If the slot was consumed (`dout_rdy`=1), `dout_en`←0, `dout`←0, `addr`←0.
- Consume and accept in the same cycle: the new word replaces the old one with no bubble. Sustained throughput is 1 word/cycle.
- No request, or `slot_free`=0: all `din_rdy` are 0. A source must hold `din`/`din_en` stable until it is accepted.
- Sources are not required to be well-behaved. `din` with `din_en`=0 is ignored. A source dropping `din_en` without being accepted is legal and is not recorded.
- No word may be duplicated or lost. The `addr` attached to a word always equals its source port index.

## Timing
- Reset (async assert, sync deassert by integration): `dout`=0, `addr`=0, `dout_en`=0, `ptr`=0, all `din_rdy`=0 while reset is asserted.
- Reset mid-operation: a held word is discarded and `ptr` returns to 0. The first grant after reset prefers port 0.
- Latency: accept at edge N, word visible on `dout`/`addr`/`dout_en` after edge N (cycle N+1).
- `din_rdy`i is a combinational function of `din_en`0..3, `ptr`, `dout_en`, and `dout_rdy`. It has no path from `din` data.
- `dout`, `addr`, `dout_en` are registered outputs with no combinational path from inputs.
- Fairness bound: a port holding `din_en`=1 is accepted within 4 output transfers.

## Structure
- Shared package `router_pkg`: `NUM_PORTS`=4, `ADDR_W`=2, a typedef for the {data, addr} slot. The router's address width comes from the same package.
- Sub-module `rr_arbiter`: 4 request inputs, `ptr` state, one-hot grant, plus an `advance` input to update `ptr`. It is reusable elsewhere.
- The top level holds the output slot register and the ready logic.
- Formal checks under `FORMAL`:
  - `dout_en`=0 implies `dout`=0 and `addr`=0.
  - `din_rdy` is one-hot or zero.
  - `din_rdy`i implies `din_en`i.
  - A stalled output (`dout_en` & ~`dout_rdy`) is stable in the next cycle.

## Test plan
- Reset, then port 2 only: `din2`=32'hA5A5_0002, `din_en2`=1, `dout_rdy`=1 → `din_rdy2`=1 in cycle 0; in cycle 1, `dout`=32'hA5A5_0002, `addr`=2, `dout_en`=1; `ptr`=3.
- All four valid continuously, `dout_rdy`=1, from reset → `addr` sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Stall: word from port 1 held, `dout_rdy`=0 for 3 cycles with ports 0 and 3 requesting → `dout`/`addr`=1 stable, all `din_rdy`=0. `dout_rdy`=1 → same-cycle accept of port 3 (ptr=2), then port 0.
- Wrap-around: `ptr`=3, ports 0 and 3 request → port 3 granted, `ptr` wraps to 0, next grant is port 0.
- Reset mid-stream: assert `resetn`=0 while `dout_en`=1, `addr`=2 → outputs 0 immediately. After release with ports 1 and 0 requesting, port 0 is granted first.
- Loopback: merge→router with random valids on all ports → every word appears on router output `dout`i matching its source index i; counts in equal counts out.

Source files
------------

// File: rtl/router_merge_pkg.sv
// rtl/router_merge_pkg.sv - shared port count, address width and slot typedef for merge/router
package router_pkg;

  localparam int NUM_PORTS = 4;
  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 32;

  typedef logic [ADDR_W-1:0] addr_t;

  // One output slot: the word plus the index of the port it came from
  typedef struct packed {
    logic [DATA_W-1:0] data;
    addr_t             addr;
  } slot_t;

  // One-hot grant to port index; all-zero input maps to 0
  function automatic addr_t oh2idx(input logic [NUM_PORTS-1:0] oh);
    addr_t idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (oh[i]) idx = addr_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/router_merge_if.sv
// rtl/router_merge_if.sv - four source ports plus the merged output stream
interface router_merge_if #(parameter int DATA_WIDTH = router_pkg::DATA_W);
  import router_pkg::*;

  logic [DATA_WIDTH-1:0] din0, din1, din2, din3;
  logic                  din_en0, din_en1, din_en2, din_en3;
  logic                  din_rdy0, din_rdy1, din_rdy2, din_rdy3;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_en;
  addr_t                 addr;
  logic                  dout_rdy;

  // Merge block side
  modport slave (
    input  din0, din1, din2, din3,
    input  din_en0, din_en1, din_en2, din_en3,
    output din_rdy0, din_rdy1, din_rdy2, din_rdy3,
    output dout, dout_en, addr,
    input  dout_rdy
  );

  // Sources and downstream consumer side
  modport master (
    output din0, din1, din2, din3,
    output din_en0, din_en1, din_en2, din_en3,
    input  din_rdy0, din_rdy1, din_rdy2, din_rdy3,
    input  dout, dout_en, addr,
    output dout_rdy
  );

endinterface

// File: rtl/router_merge_rr_arbiter.sv
// rtl/router_merge_rr_arbiter.sv - four-way round-robin arbiter with one-hot grant
module rr_arbiter
  import router_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_advance,
  output logic [NUM_PORTS-1:0] o_grant,
  output addr_t                o_grant_idx
);

  addr_t r_ptr;
  addr_t w_idx;

  // First requester scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  always_comb begin
    o_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = r_ptr + addr_t'(k);
      if ((o_grant == '0) && i_req[w_idx]) o_grant[w_idx] = 1'b1;
    end
  end

  assign o_grant_idx = oh2idx(o_grant);

  // Pointer moves just past the served port only when the grant is actually taken
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= o_grant_idx + addr_t'(1);
    end
  end

endmodule

// File: rtl/router_merge.sv
// rtl/router_merge.sv - four-to-one round-robin merge with a single registered output slot
module router_merge
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic          clk,
  input  logic          resetn,
  router_merge_if.slave bus
);

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_grant;
  logic [NUM_PORTS-1:0]  w_rdy;
  addr_t                 w_gidx;
  logic                  w_slot_free;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_sel_data;
  slot_t                 r_slot;
  logic                  r_valid;

  assign w_req       = {bus.din_en3, bus.din_en2, bus.din_en1, bus.din_en0};
  assign w_slot_free = ~r_valid | bus.dout_rdy;
  // resetn gates ready so no source sees an accept while the slot is held in reset
  assign w_rdy       = w_grant & {NUM_PORTS{w_slot_free & resetn}};
  assign w_accept    = |w_rdy;

  rr_arbiter u_arb (
    .clk        (clk),
    .resetn     (resetn),
    .i_req      (w_req),
    .i_advance  (w_accept),
    .o_grant    (w_grant),
    .o_grant_idx(w_gidx)
  );

  // Select the granted port's data; only consumed when an accept happens
  always_comb begin
    w_sel_data = '0;
    case (w_gidx)
      2'd0:    w_sel_data = bus.din0;
      2'd1:    w_sel_data = bus.din1;
      2'd2:    w_sel_data = bus.din2;
      default: w_sel_data = bus.din3;
    endcase
  end

  // Output slot: load on accept (replacing a consumed word), clear when drained
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_slot  <= '{data: w_sel_data, addr: w_gidx};
      r_valid <= 1'b1;
    end else if (bus.dout_rdy) begin
      r_slot  <= '0;
      r_valid <= 1'b0;
    end
  end

  assign bus.din_rdy0 = w_rdy[0];
  assign bus.din_rdy1 = w_rdy[1];
  assign bus.din_rdy2 = w_rdy[2];
  assign bus.din_rdy3 = w_rdy[3];
  assign bus.dout     = r_slot.data;
  assign bus.addr     = r_slot.addr;
  assign bus.dout_en  = r_valid;

`ifdef FORMAL
  a_idle_zero:  assert property (@(posedge clk) disable iff (!resetn) !r_valid |-> (r_slot == '0));
  a_rdy_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(w_rdy));
  a_rdy_has_en: assert property (@(posedge clk) disable iff (!resetn) (w_rdy & ~w_req) == '0);
  a_stall_hold: assert property (@(posedge clk) disable iff (!resetn)
                  (r_valid && !bus.dout_rdy) |=> (r_valid && $stable(r_slot)));
`endif

endmodule

// File: tb/tb_router_merge.sv
// tb/tb_router_merge.sv - directed and random scoreboard bench for router_merge
module tb_router_merge;
  import router_pkg::*;

  typedef struct {
    logic [31:0] d;
    int          p;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_data [4];
  logic        s_en [4];
  bit          refill [4];
  logic        s_rdy;
  logic [31:0] rt_dout [4];

  exp_t sb[$];
  int   obs_addr[$];
  bit   log_addr;
  int   m_ptr;
  bit   m_valid;
  int   n_in, n_out;
  int   tests, fails;
  int   word_ctr;

  always #5 clk = ~clk;

  router_merge_if bus ();

  router_merge dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  assign bus.din0     = s_data[0];
  assign bus.din1     = s_data[1];
  assign bus.din2     = s_data[2];
  assign bus.din3     = s_data[3];
  assign bus.din_en0  = s_en[0];
  assign bus.din_en1  = s_en[1];
  assign bus.din_en2  = s_en[2];
  assign bus.din_en3  = s_en[3];
  assign bus.dout_rdy = s_rdy;

  wire [3:0] tb_rdy = {bus.din_rdy3, bus.din_rdy2, bus.din_rdy1, bus.din_rdy0};

  // Address-decoding router on the merged stream
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rt_dout[i] = (bus.dout_en && (bus.addr == i)) ? bus.dout : 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] next_word(input int p);
    word_ctr++;
    return {8'(p), 8'h5A, 16'(word_ctr)};
  endfunction

  // One clock: check at posedge+4, update model and sources at the following posedge+1
  task automatic cycle();
    int   g;
    bit   free;
    bit   rdy_s;
    logic [3:0] er;
    #3;
    free = !m_valid || s_rdy;
    g = -1;
    if (free) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (g < 0 && s_en[idx]) g = idx;
      end
    end
    er = (g >= 0) ? 4'(1 << g) : 4'b0;
    chk("din_rdy", tb_rdy, er);
    chk("dout_en", bus.dout_en, m_valid);
    chk("ptr", dut.u_arb.r_ptr, m_ptr);
    if (m_valid) begin
      chk("dout", bus.dout, sb[0].d);
      chk("addr", bus.addr, sb[0].p);
      chk("router_out", rt_dout[sb[0].p], sb[0].d);
      if (log_addr) obs_addr.push_back(int'(bus.addr));
    end else begin
      chk("dout_idle", bus.dout, 0);
      chk("addr_idle", bus.addr, 0);
    end
    rdy_s = s_rdy;
    @(posedge clk);
    #1;
    if (m_valid && rdy_s) begin
      void'(sb.pop_front());
      n_out++;
    end
    if (g >= 0) begin
      sb.push_back('{d: s_data[g], p: g});
      n_in++;
      m_ptr = (g + 1) % 4;
      m_valid = 1;
      if (refill[g]) s_data[g] = next_word(g);
      else s_en[g] = 1'b0;
    end else if (rdy_s) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("reset_dout_en", bus.dout_en, 0);
    chk("reset_dout", bus.dout, 0);
    chk("reset_addr", bus.addr, 0);
    chk("reset_rdy", tb_rdy, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_ptr", dut.u_arb.r_ptr, 0);
    resetn = 1'b1;
    m_ptr = 0;
    m_valid = 0;
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) begin
      s_en[i] = 1'b0;
      refill[i] = 0;
    end
    s_rdy = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    int exp_seq[6];
    exp_seq = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      s_data[i] = '0;
      s_en[i] = 1'b0;
      refill[i] = 0;
    end
    s_rdy = 1'b0;
    #1;

    // Reset with a requester present, then a single word from port 2
    s_en[2] = 1'b1;
    s_data[2] = 32'hA5A5_0002;
    do_reset();
    s_rdy = 1'b1;
    cycle();
    cycle();
    drain();

    // All four continuously valid from reset: 0,1,2,3,0,1 with no bubbles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s_en[i] = 1'b1;
      refill[i] = 1;
      s_data[i] = next_word(i);
    end
    s_rdy = 1'b1;
    log_addr = 1;
    for (int i = 0; i < 7; i++) cycle();
    log_addr = 0;
    chk("seq_len", obs_addr.size(), 6);
    if (obs_addr.size() >= 6) begin
      for (int i = 0; i < 6; i++) chk("addr_seq", obs_addr[i], exp_seq[i]);
    end
    drain();

    // Stall with port 1 held while ports 0 and 3 wait
    do_reset();
    s_en[1] = 1'b1;
    s_data[1] = next_word(1);
    s_rdy = 1'b1;
    cycle();
    s_rdy = 1'b0;
    s_en[0] = 1'b1;
    s_data[0] = next_word(0);
    s_en[3] = 1'b1;
    s_data[3] = next_word(3);
    for (int i = 0; i < 3; i++) cycle();
    s_rdy = 1'b1;
    cycle();
    cycle();
    drain();

    // Wrap-around from ptr=3
    do_reset();
    s_en[2] = 1'b1;
    s_data[2] = next_word(2);
    s_rdy = 1'b1;
    cycle();
    s_en[0] = 1'b1;
    s_data[0] = next_word(0);
    s_en[3] = 1'b1;
    s_data[3] = next_word(3);
    cycle();
    cycle();
    drain();

    // Reset while a word from port 2 is held
    do_reset();
    s_en[2] = 1'b1;
    s_data[2] = next_word(2);
    s_rdy = 1'b0;
    cycle();
    chk("pre_reset_valid", bus.dout_en, 1);
    chk("pre_reset_addr", bus.addr, 2);
    s_en[1] = 1'b1;
    s_data[1] = next_word(1);
    s_en[0] = 1'b1;
    s_data[0] = next_word(0);
    do_reset();
    #2;
    chk("post_reset_grant", tb_rdy, 4'b0001);
    s_rdy = 1'b1;
    cycle();
    cycle();
    drain();

    // Random loopback with irregular sources and back-pressure
    do_reset();
    n_in = 0;
    n_out = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!s_en[i] && ($urandom % 3 == 0)) begin
          s_en[i] = 1'b1;
          s_data[i] = next_word(i);
        end else if (s_en[i] && ($urandom % 16 == 0)) begin
          s_en[i] = 1'b0;
          s_data[i] = $urandom;
        end
      end
      s_rdy = ($urandom % 4) != 0;
      cycle();
    end
    drain();
    chk("count_in_out", n_in, n_out);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
